ram_frame_reader: RTL

//   Read-side consumer for the ping-pong sample buffer. Drains one buffered frame of DEPTH signed samples
//   via valid/ready and re-streams them downstream through a single-register stage, tagged with first/last.

---
 rtl/ram_frame_reader.sv | 117 +++++++++++
 1 files changed

// File: rtl/ram_frame_reader.sv
// rtl/ram_frame_reader.sv - drains one ping-pong buffer frame, re-streams it with first/last tags, reports per-frame peak |sample|
module ram_frame_reader #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int IDX_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [WIDTH-1:0]     rd_data_i,
    input  logic                 rd_valid_i,
    output logic                 rd_ready_o,
    output logic [WIDTH-1:0]     sample_o,
    output logic                 sample_valid_o,
    input  logic                 sample_ready_i,
    output logic                 sample_first_o,
    output logic                 sample_last_o,
    output logic [IDX_WIDTH-1:0] sample_idx_o,
    output logic [WIDTH-1:0]     peak_o,
    output logic                 peak_valid_o,
    output logic [CNT_WIDTH-1:0] frame_count_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, REPORT} state_t;

    localparam logic [WIDTH-1:0]     MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

    state_t               state, state_nxt;
    logic [IDX_WIDTH-1:0] idx;
    logic [WIDTH-1:0]     running_peak;
    logic [WIDTH-1:0]     abs_data;
    logic                 up_xfer;
    logic                 dn_xfer;
    logic                 drain_done;
    logic                 last_xfer;

    // The most negative sample has no positive twin, so it clamps to the largest positive value.
    always_comb begin
        abs_data = rd_data_i;
        if (rd_data_i[WIDTH-1]) begin
            if (rd_data_i == MIN_NEG) begin
                abs_data = MAX_POS;
            end else begin
                abs_data = {WIDTH{1'b0}} - rd_data_i;
            end
        end
    end

    assign rd_ready_o   = (state == STREAM) && (!sample_valid_o || sample_ready_i);
    assign up_xfer      = rd_valid_i && rd_ready_o;
    assign dn_xfer      = sample_valid_o && sample_ready_i;
    assign drain_done   = !sample_valid_o || sample_ready_i;
    assign last_xfer    = up_xfer && (idx == LAST_IDX);
    assign sample_idx_o = idx;
    assign peak_valid_o = (state == REPORT);
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_i) state_nxt = STREAM;
            STREAM:  if (last_xfer) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = REPORT;
            REPORT:  state_nxt = enable_i ? STREAM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx            <= '0;
            running_peak   <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            sample_first_o <= 1'b0;
            sample_last_o  <= 1'b0;
            peak_o         <= '0;
            frame_count_o  <= '0;
        end else begin
            if (up_xfer) begin
                sample_o       <= rd_data_i;
                sample_valid_o <= 1'b1;
                sample_first_o <= (idx == '0);
                sample_last_o  <= (idx == LAST_IDX);
                if (abs_data > running_peak) begin
                    running_peak <= abs_data;
                end
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_WIDTH'(1);
            end else if (dn_xfer) begin
                sample_valid_o <= 1'b0;
            end

            // Publish on entry to REPORT so peak_o/frame_count_o are already valid during the pulse.
            if (state == DRAIN && drain_done) begin
                peak_o        <= running_peak;
                frame_count_o <= frame_count_o + CNT_WIDTH'(1);
            end

            if (state == REPORT) begin
                running_peak <= '0;
            end
        end
    end

endmodule
